// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file: 1W/2R, zero reg, bypass, sequenced clear, write-drop error
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] S_Addr,
    input  logic [ADDR_W-1:0] T_Addr,
    input  logic [DATA_W-1:0] D,
    input  logic              D_En,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic              clr,
    output logic [DATA_W-1:0] S,
    output logic [DATA_W-1:0] T,
    output logic              busy,
    output logic              wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              wr_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_req;
    logic byp_s;
    logic byp_t;

    assign wr_req = D_En && (D_Addr != '0);
    assign ptr_d  = ptr_q + PTR_ONE;

    // Entry 0 is never written, so excluding it from bypass falls out of wr_req.
    assign byp_s = (BYPASS != 0) && (state_q == ST_IDLE) && wr_req && (D_Addr == S_Addr);
    assign byp_t = (BYPASS != 0) && (state_q == ST_IDLE) && wr_req && (D_Addr == T_Addr);

    always_comb begin
        S = '0;
        T = '0;
        if (byp_s) begin
            S = D;
        end else if (S_Addr != '0) begin
            S = mem_q[S_Addr];
        end
        if (byp_t) begin
            T = D;
        end else if (T_Addr != '0) begin
            T = mem_q[T_Addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        mem_q[D_Addr] <= D;
                    end
                    // A same-edge write still lands; the sweep will clear it later.
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= PTR_ONE;
                    end
                end
                ST_CLEAR: begin
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_d;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                    end
                    if (wr_req) begin
                        wr_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign busy   = (state_q == ST_CLEAR);
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param (bypass and non-bypass instances)
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic [4:0]  S_Addr, T_Addr, D_Addr;
    logic [31:0] D;
    logic        D_En, clr;
    logic [31:0] S, T, S0, T0;
    logic        busy, wr_err, busy0, wr_err0;

    int total;
    int bad;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .S_Addr(S_Addr), .T_Addr(T_Addr), .D(D),
        .D_En(D_En), .D_Addr(D_Addr), .clr(clr), .S(S), .T(T),
        .busy(busy), .wr_err(wr_err)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .S_Addr(S_Addr), .T_Addr(T_Addr), .D(D),
        .D_En(D_En), .D_Addr(D_Addr), .clr(clr), .S(S0), .T(T0),
        .busy(busy0), .wr_err(wr_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
        D_En = 1'b1; D_Addr = a; D = v;
        tick();
        D_En = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0 || wr_err !== 1'b0) begin bad++; $display("FAIL rst_init busy=%b wr_err=%b want 0 0", busy, wr_err); end
        write_reg(5'd5, 32'hDEADBEEF);
        S_Addr = 5'd5; #1;
        total++; if (S !== 32'hDEADBEEF) begin bad++; $display("FAIL preload S=%h want deadbeef", S); end
        #1 reset = 1'b0; #1;
        total++; if (S !== 32'h0) begin bad++; $display("FAIL rst_async S=%h want 0", S); end
        total++; if (busy !== 1'b0 || wr_err !== 1'b0) begin bad++; $display("FAIL rst_flags busy=%b wr_err=%b want 0 0", busy, wr_err); end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_zero_write();
        write_reg(5'd0, 32'h1234_5678);
        write_reg(5'd7, 32'hA5A5_A5A5);
        S_Addr = 5'd0; T_Addr = 5'd7; #1;
        total++; if (S !== 32'h0) begin bad++; $display("FAIL zero_reg S=%h want 0", S); end
        total++; if (T !== 32'hA5A5_A5A5) begin bad++; $display("FAIL basic_write T=%h want a5a5a5a5", T); end
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL no_err wr_err=%b want 0", wr_err); end
    endtask

    task automatic test_bypass();
        write_reg(5'd3, 32'h1111_2222);
        write_reg(5'd4, 32'h4444_4444);
        D_En = 1'b1; D_Addr = 5'd3; D = 32'hCAFE_F00D; S_Addr = 5'd3; T_Addr = 5'd3; #1;
        total++; if (S !== 32'hCAFE_F00D || T !== 32'hCAFE_F00D) begin bad++; $display("FAIL bypass_both S=%h T=%h want cafef00d", S, T); end
        total++; if (S0 !== 32'h1111_2222 || T0 !== 32'h1111_2222) begin bad++; $display("FAIL nobypass S=%h T=%h want 11112222", S0, T0); end
        tick();
        D_En = 1'b0; #1;
        total++; if (S0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL nobypass_after S=%h want cafef00d", S0); end
        D_En = 1'b1; D_Addr = 5'd4; D = 32'h5555_0000; S_Addr = 5'd3; T_Addr = 5'd4; #1;
        total++; if (S !== 32'hCAFE_F00D || T !== 32'h5555_0000) begin bad++; $display("FAIL bypass_indep S=%h T=%h want cafef00d 55550000", S, T); end
        D_Addr = 5'd0; D = 32'hFFFF_FFFF; S_Addr = 5'd0; #1;
        total++; if (S !== 32'h0) begin bad++; $display("FAIL bypass_zero S=%h want 0", S); end
        D_En = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int cnt;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            if (cnt == 9) begin
                S_Addr = 5'd9; #1;
                total++; if (S !== 32'h0) begin bad++; $display("FAIL mid_clear_lo S(9)=%h want 0", S); end
                S_Addr = 5'd20; #1;
                total++; if (S !== 32'd20) begin bad++; $display("FAIL mid_clear_hi S(20)=%h want 14", S); end
            end
            tick();
            cnt++;
        end
        total++; if (cnt !== 31) begin bad++; $display("FAIL clear_len busy_cycles=%0d want 31", cnt); end
        for (int i = 0; i < 32; i++) begin
            S_Addr = 5'(i); T_Addr = 5'(i); #1;
            total++; if (S !== 32'h0 || T0 !== 32'h0) begin bad++; $display("FAIL cleared reg=%0d S=%h T0=%h want 0", i, S, T0); end
        end
    endtask

    task automatic test_dropped_write();
        int cnt;
        write_reg(5'd31, 32'h55);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        tick(); cnt++;
        tick(); cnt++;
        D_En = 1'b1; D_Addr = 5'd31; D = 32'h0000_00FF; S_Addr = 5'd31; clr = 1'b1; #1;
        total++; if (S !== 32'h55) begin bad++; $display("FAIL clear_nobypass S=%h want 55", S); end
        tick(); cnt++;
        D_En = 1'b0; clr = 1'b0;
        total++; if (wr_err !== 1'b1 || wr_err0 !== 1'b1) begin bad++; $display("FAIL wr_err_pulse wr_err=%b want 1", wr_err); end
        tick(); cnt++;
        total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wr_err_len wr_err=%b want 0", wr_err); end
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++; if (cnt !== 31) begin bad++; $display("FAIL clr_ignored busy_cycles=%0d want 31", cnt); end
        S_Addr = 5'd31; #1;
        total++; if (S !== 32'h0) begin bad++; $display("FAIL dropped_data S(31)=%h want 0", S); end
    endtask

    task automatic test_reset_mid_clear();
        write_reg(5'd20, 32'h20);
        write_reg(5'd30, 32'h30);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_abort busy=%b want 1", busy); end
        #1 reset = 1'b0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy busy=%b want 0", busy); end
        for (int i = 0; i < 32; i++) begin
            S_Addr = 5'(i); #0.1;
            total++; if (S !== 32'h0) begin bad++; $display("FAIL abort_zero reg=%0d S=%h want 0", i, S); end
        end
        #1 reset = 1'b1;
        D_En = 1'b1; D_Addr = 5'd2; D = 32'h2222_2222;
        tick();
        D_En = 1'b0; S_Addr = 5'd2; #1;
        total++; if (S !== 32'h2222_2222 || busy !== 1'b0) begin bad++; $display("FAIL post_abort_write S=%h busy=%b want 22222222 0", S, busy); end
    endtask

    task automatic test_clr_held();
        int cnt;
        clr = 1'b1;
        tick();
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        total++; if (cnt !== 31 || busy !== 1'b0) begin bad++; $display("FAIL held_first busy_cycles=%0d want 31", cnt); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_reenter busy=%b want 1", busy); end
        clr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        write_reg(5'd6, 32'h6666);
        S_Addr = 5'd6; #1;
        total++; if (S !== 32'h6666) begin bad++; $display("FAIL first_after_clear S=%h want 6666", S); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; S_Addr = '0; T_Addr = '0; D_Addr = '0; D = '0; D_En = 1'b0; clr = 1'b0;
        #12 reset = 1'b1;
        tick();
        test_reset();
        test_zero_write();
        test_bypass();
        test_clear();
        test_dropped_write();
        test_reset_mid_clear();
        test_clr_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
